// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: datapath width, ALU opcodes,
// EX_signals bit positions and operand-forwarding select codes.
package execute_stage_pkg;
   localparam int W = 16;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_NOT = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_MOV = 4'd10;
   localparam logic [3:0] OP_LDM = 4'd11;

   localparam int EX_IMM_SEL  = 4;
   localparam int EX_FLAGS_WE = 5;
   localparam int EX_JZ       = 6;
   localparam int EX_JN       = 7;
   localparam int EX_JC       = 8;
   localparam int EX_JMP      = 9;
   localparam int EX_SETC     = 10;
   localparam int EX_CLRC     = 11;
   localparam int EX_RESTORE  = 12;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;
endpackage

// File: rtl/execute_stage_if.sv
// Bundle of decode-side inputs and E/M-side outputs of the execute stage.
interface execute_stage_if;
   import execute_stage_pkg::*;
   logic         en;
   logic         flush;
   logic [12:0]  EX_signals;
   logic [6:0]   MEM_signals;
   logic [5:0]   WB_signals;
   logic [W-1:0] Rsrc;
   logic [W-1:0] Rdst;
   logic [W-1:0] imm;
   logic [1:0]   fwd_src_sel;
   logic [1:0]   fwd_dst_sel;
   logic [W-1:0] mem_fwd;
   logic [W-1:0] wb_fwd;
   logic         flags_save;
   logic         branch_taken;
   logic [W-1:0] branch_target;
   logic [2:0]   ccr;
   logic [W-1:0] em_result;
   logic [W-1:0] em_rdst;
   logic [6:0]   em_mem;
   logic [5:0]   em_wb;

   modport master (
      output en, flush, EX_signals, MEM_signals, WB_signals, Rsrc, Rdst, imm,
             fwd_src_sel, fwd_dst_sel, mem_fwd, wb_fwd, flags_save,
      input  branch_taken, branch_target, ccr, em_result, em_rdst, em_mem, em_wb
   );
   modport slave (
      input  en, flush, EX_signals, MEM_signals, WB_signals, Rsrc, Rdst, imm,
             fwd_src_sel, fwd_dst_sel, mem_fwd, wb_fwd, flags_save,
      output branch_taken, branch_target, ccr, em_result, em_rdst, em_mem, em_wb
   );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU: result plus Z/N/C; c_upd says whether C should be written.
module alu
   import execute_stage_pkg::*;
(
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] imm,
   output logic [W-1:0] result,
   output logic         z,
   output logic         n,
   output logic         c,
   output logic         c_upd
);
   logic [3:0] shamt;
   logic [W:0] wide;
   logic [W:0] sr;

   assign shamt = imm[3:0];
   // Right shift carries a guard bit below B so the last bit out lands in sr[0].
   assign sr = {b, 1'b0} >> shamt;

   always_comb begin
      wide  = '0;
      c_upd = 1'b1;
      case (op)
         OP_NOP: wide = {1'b0, a};
         OP_NOT: begin wide = {1'b0, ~b}; c_upd = 1'b0; end
         OP_INC: wide = {1'b0, b} + (W+1)'(1);
         OP_DEC: wide = {1'b0, b} - (W+1)'(1);
         OP_ADD: wide = {1'b0, a} + {1'b0, b};
         OP_SUB: wide = {1'b0, b} - {1'b0, a};
         OP_AND: begin wide = {1'b0, a & b}; c_upd = 1'b0; end
         OP_OR:  begin wide = {1'b0, a | b}; c_upd = 1'b0; end
         OP_SHL: begin wide = {1'b0, b} << shamt; c_upd = (shamt != 4'd0); end
         OP_SHR: begin wide = {sr[0], sr[W:1]}; c_upd = (shamt != 4'd0); end
         OP_MOV: wide = {1'b0, a};
         OP_LDM: wide = {1'b0, imm};
         default: wide = '0;
      endcase
   end

   assign result = wide[W-1:0];
   assign c      = wide[W];
   assign z      = (result == '0);
   assign n      = result[W-1];
endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, CCR with interrupt shadow,
// branch resolution and the E/M pipeline buffer.
module execute_stage
   import execute_stage_pkg::*;
(
   input logic clk,
   input logic rst,
   execute_stage_if.slave bus
);
   logic [W-1:0] src_f, dst_f, op_b, alu_res;
   logic         alu_z, alu_n, alu_c, alu_c_upd;
   logic [2:0]   ccr_q, ccr_d, shadow_q;
   logic [W-1:0] em_result_q, em_rdst_q;
   logic [6:0]   em_mem_q;
   logic [5:0]   em_wb_q;
   logic [12:0]  ex;

   assign ex = bus.EX_signals;

   always_comb begin
      case (bus.fwd_src_sel)
         FWD_MEM: src_f = bus.mem_fwd;
         FWD_WB:  src_f = bus.wb_fwd;
         default: src_f = bus.Rsrc;
      endcase
      case (bus.fwd_dst_sel)
         FWD_MEM: dst_f = bus.mem_fwd;
         FWD_WB:  dst_f = bus.wb_fwd;
         default: dst_f = bus.Rdst;
      endcase
   end

   assign op_b = ex[EX_IMM_SEL] ? bus.imm : dst_f;

   alu u_alu (
      .op(ex[3:0]), .a(src_f), .b(op_b), .imm(bus.imm),
      .result(alu_res), .z(alu_z), .n(alu_n), .c(alu_c), .c_upd(alu_c_upd)
   );

   // ccr_q = {C,N,Z}; branch decisions use the flags before this cycle's update.
   assign bus.branch_taken = rst & ~bus.flush &
      ((ex[EX_JZ] & ccr_q[0]) | (ex[EX_JN] & ccr_q[1]) |
       (ex[EX_JC] & ccr_q[2]) | ex[EX_JMP]);

   always_comb begin
      ccr_d = ccr_q;
      if (bus.en) begin
         if (!bus.flush) begin
            if (ex[EX_FLAGS_WE]) begin
               ccr_d[0] = alu_z;
               ccr_d[1] = alu_n;
               if (alu_c_upd) ccr_d[2] = alu_c;
            end
            if (ex[EX_SETC])      ccr_d[2] = 1'b1;
            else if (ex[EX_CLRC]) ccr_d[2] = 1'b0;
            if (ex[EX_JZ] & ccr_q[0]) ccr_d[0] = 1'b0;
            if (ex[EX_JN] & ccr_q[1]) ccr_d[1] = 1'b0;
            if (ex[EX_JC] & ccr_q[2]) ccr_d[2] = 1'b0;
         end
         if (ex[EX_RESTORE]) ccr_d = shadow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ccr_q       <= '0;
         shadow_q    <= '0;
         em_result_q <= '0;
         em_rdst_q   <= '0;
         em_mem_q    <= '0;
         em_wb_q     <= '0;
      end else begin
         ccr_q <= ccr_d;
         // Save ignores the stall so an interrupt entry is never lost.
         if (bus.flags_save) shadow_q <= ccr_q;
         if (bus.en) begin
            em_result_q <= alu_res;
            em_rdst_q   <= dst_f;
            em_mem_q    <= bus.flush ? 7'd0 : bus.MEM_signals;
            em_wb_q     <= bus.flush ? 6'd0 : bus.WB_signals;
         end
      end
   end

   assign bus.branch_target = dst_f;
   assign bus.ccr           = ccr_q;
   assign bus.em_result     = em_result_q;
   assign bus.em_rdst       = em_rdst_q;
   assign bus.em_mem        = em_mem_q;
   assign bus.em_wb         = em_wb_q;
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 W, 16, datapath width.
REQ-002 clk  in  1  rising-edge clock for every register in the block.
REQ-003 rst  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 en  in  1  E/M buffer and CCR update enable; 0 = stall/freeze.
REQ-005 flush  in  1  bubble insert: zero the control fields of the E/M buffer and suppress the flag write.
REQ-006 EX_signals  in  13  [3:0] alu_op, [4] imm_sel, [5] flags_we, [6] jz, [7] jn, [8] jc, [9] jmp, [10] setc, [11] clrc, [12] flags_restore.
REQ-007 MEM_signals  in  7  passed through to the E/M buffer.
REQ-008 WB_signals  in  6  passed through to the E/M buffer.
REQ-009 Rsrc, Rdst  in  W  operands from decode.
REQ-010 imm  in  W  immediate / shift amount.
REQ-011 fwd_src_sel, fwd_dst_sel  in  2  operand select: 0 = register, 1 = mem_fwd, 2 = wb_fwd, 3 = register.
REQ-012 mem_fwd, wb_fwd  in  W  forwarded results.
REQ-013 flags_save  in  1  interrupt entry pulse: copy CCR into the shadow register.
REQ-014 branch_taken  out  1  combinational; drives decode's branch_signal.
REQ-015 branch_target  out  W  forwarded Rdst.
REQ-016 ccr  out  3  {C,N,Z} current flags.
REQ-017 em_result, em_rdst  out  W  registered ALU result and forwarded Rdst.
REQ-018 em_mem, em_wb  out  7, 6  registered MEM_signals and WB_signals.

Function
REQ-019 Operand A SHALL be the forwarded Rsrc; operand B SHALL be imm when imm_sel=1, else the forwarded Rdst.
REQ-020 alu_op encoding SHALL be:
- 0 NOP (result = A)
- 1 NOT B
- 2 INC B
- 3 DEC B
- 4 ADD
- 5 SUB (B-A)
- 6 AND
- 7 OR
- 8 SHL B by imm[3:0]
- 9 SHR B by imm[3:0]
- 10 MOV A
- 11 LDM imm
- 12-15 result = 0.
REQ-021 Arithmetic SHALL be computed at W+1 bits. C = bit W for ADD/INC; C = borrow for SUB/DEC; C = last bit shifted out for a shift, unchanged when the shift amount is 0. Z = (result==0). N = result[W-1].
REQ-022 When flags_we=1, en=1 and flush=0, the CCR SHALL load the new Z/N/C on the next edge. Ops 1, 6 and 7 SHALL update Z and N only.
REQ-023 setc SHALL force C=1 and clrc SHALL force C=0; both take priority over the ALU C.
REQ-024 branch_taken SHALL be (jz&Z)|(jn&N)|(jc&C)|jmp, evaluated on the pre-update CCR, and forced to 0 when flush=1.
REQ-025 A taken conditional jump SHALL clear its tested flag on the next edge.
REQ-026 flags_restore=1 SHALL load the CCR from the shadow register, overriding every other CCR source.
REQ-027 When flags_save and flags_restore are both 1 in one cycle, CCR and shadow SHALL swap.
REQ-028 The E/M buffer SHALL have latency 1, load only when en=1, and hold its value when en=0. flush=1 with en=1 SHALL load em_mem=0 and em_wb=0; the data fields are don't-care.
REQ-029 en=0 SHALL freeze the CCR but SHALL NOT block flags_save.

Reset
REQ-030 rst=0 at a rising edge SHALL clear the CCR, the shadow register and all em_* outputs to 0, overriding en, flush and flags_save.
REQ-031 While rst=0, branch_taken SHALL be 0.
REQ-032 Reset asserted mid-stall SHALL clear the block and leave no residual state.

Structure
REQ-033 A shared package SHALL hold the alu_op constants, the EX_signals bit indices, the forward-select codes and W.
REQ-034 A combinational sub-module alu SHALL compute result and flags.
REQ-035 The forwarding muxes, CCR, shadow register, branch logic and E/M buffer SHALL reside in execute_stage.

Verification
REQ-036 Bench SHALL cover ADD with A=0xFFFF, B=0x0001, flags_we=1 -> em_result=0x0000, ccr={C=1,N=0,Z=1} one cycle later.
REQ-037 Bench SHALL cover CCR Z=1 then jz=1 -> branch_taken=1 in the same cycle and Z=0 after the edge; jz=1 with Z=0 -> branch_taken=0.
REQ-038 Bench SHALL cover fwd_src_sel=1 with mem_fwd=0x1234 and MOV -> em_result=0x1234.
REQ-039 Bench SHALL cover CCR=3'b101 and flags_save=1, then a SUB that sets Z, then flags_restore=1 -> ccr=3'b101.
REQ-040 Bench SHALL cover en=0 for 3 cycles with changing inputs -> em_* and ccr held; flush=1 with en=1 -> em_mem=0, em_wb=0, branch_taken=0.
REQ-041 Bench SHALL cover rst=0 during a stall with CCR=3'b111 -> all outputs 0 at the next edge.
